hermes_ni_sender: RTL and testbench
===================================

Name: hermes_ni_sender

Overview:
- Network-interface transmitter that injects packets into a router local input port (rx/data_in/credit_o side), using Hermes credit-based flow control.
- Takes a packet descriptor (target address, payload size) plus a payload stream from the core side.
- Serialises header flit, size flit and payload flits onto tx/data_out, honouring credit_i.
- Sits between the processing-element DMA/NI logic and RouterCC local port.

Parameters:
- FLIT_WIDTH, 16, width of flits, target field and size field
- SIZE_WIDTH, 16, width of internal remaining-flit counter (size field zero-extended/truncated to this)

Ports:
- clock  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-low reset
- send_start  in  1  request to send a packet; sampled only when busy=0
- send_target  in  FLIT_WIDTH  header flit value (router address), latched on accepted start
- send_size  in  FLIT_WIDTH  number of payload flits, latched on accepted start
- busy  out  1  packet in progress
- payload_valid  in  1  core presents a payload flit
- payload_data  in  FLIT_WIDTH  payload flit
- payload_ready  out  1  payload flit consumed this cycle when payload_valid=1
- clock_tx  out  1  forwarded clock; equals clock
- tx  out  1  data_out holds a valid flit (registered)
- data_out  out  FLIT_WIDTH  flit to router (registered)
- credit_i  in  1  router has buffer space; flit transfers on rising edge where tx=1 and credit_i=1
- pkt_sent  out  1  one-cycle pulse after the last flit of a packet transfers

Behaviour:
- Reset (asynchronous, active-low, immediate):
  - state=IDLE; tx=0; data_out=0; busy=0; payload_ready=0; pkt_sent=0.
  - Counters and latched target/size cleared.
  - Reset mid-packet abandons the packet and drops tx at once; no pkt_sent.
- Output stage: single register (tx, data_out).
  - drain = tx & credit_i.
  - Stage may load when !tx | credit_i; otherwise tx and data_out hold stable.
  - credit_i while tx=0 is ignored.
- FSM states: IDLE, HDR, SIZE, PLD, DONE. busy = (state != IDLE).
- IDLE:
  - send_start=1 latches target, size and remaining=size, goes to HDR, and loads stage with target (tx=1 next cycle).
  - send_start while busy is ignored.
- HDR: on drain, load size flit into stage and go to SIZE.
- SIZE: on drain:
  - if remaining=0, tx<=0 and go to DONE;
  - else go to PLD and try to load the first payload in the same cycle using the PLD load rule.
- PLD:
  - payload_ready = (state==PLD | SIZE draining) & remaining>0 & (!tx | credit_i). This is combinational from state, tx and credit_i.
  - Load on payload_valid & payload_ready: data_out<=payload_data, tx<=1, remaining--.
  - No load while the stage drains: tx<=0 (bubble).
  - When remaining=0 and the last flit drains: tx<=0, go to DONE.
- DONE: pkt_sent=1 for exactly one cycle, then IDLE. A new start is accepted in the following cycle.
- Latency and throughput:
  - start at edge N -> header on data_out in cycle N+1.
  - With credit_i=1 continuously and payload always valid, one flit per cycle.
  - Total packet occupies 2+size consecutive tx cycles.
- Size arithmetic:
  - remaining is unsigned SIZE_WIDTH.
  - Size 0 is legal (header + size flit only).
  - No wrap: decrement only when remaining>0.
- payload_ready is never asserted outside SIZE/PLD; payload beyond size is never consumed.

Test Plan:
- Basic packet: target=0x0011, size=3, payload 0xA1,0xA2,0xA3 valid, credit_i=1 -> data_out 0x0011,0x0003,0xA1,0xA2,0xA3 on 5 consecutive tx=1 cycles; pkt_sent pulses the next cycle; busy drops after it.
- Backpressure: same packet, credit_i=0 for 4 cycles while header is presented -> tx=1, data_out=0x0011 stable all 4 cycles, payload_ready=0; the sequence then resumes unchanged.
- Payload bubbles: size=2, payload_valid low for 2 cycles between flits -> tx=0 during the gap; ordering 0x0011,0x0002,P0,P1 preserved; pkt_sent once.
- Zero size: target=0x0102, size=0 -> exactly 2 flits (0x0102,0x0000), payload_ready never high, pkt_sent pulses.
- Start while busy: second send_start during packet 1 -> ignored; only packet 1 flits appear; busy low after pkt_sent.
- Reset mid-packet: assert reset low during payload flit 2 of size 5 -> tx=0, busy=0 immediately; after release, a fresh size=1 packet sends 3 flits correctly.

Source files
------------

// File: rtl/hermes_ni_sender.sv
// Hermes network-interface sender: serialises header, size and payload flits
// into a router local port using credit-based flow control.
module hermes_ni_sender #(
    parameter int FLIT_WIDTH = 16,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  send_start,
    input  logic [FLIT_WIDTH-1:0] send_target,
    input  logic [FLIT_WIDTH-1:0] send_size,
    output logic                  busy,
    input  logic                  payload_valid,
    input  logic [FLIT_WIDTH-1:0] payload_data,
    output logic                  payload_ready,
    output logic                  clock_tx,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_out,
    input  logic                  credit_i,
    output logic                  pkt_sent
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SIZE,
        PLD,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  tx_q, tx_d;
    logic [FLIT_WIDTH-1:0] data_q, data_d;
    logic [FLIT_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;

    logic drain;
    logic stageFree;
    logic hasRemaining;
    logic pldWindow;
    logic pldLoad;

    // The output stage empties on a credited transfer; it may refill in that same cycle.
    assign drain        = tx_q & credit_i;
    assign stageFree    = ~tx_q | credit_i;
    assign hasRemaining = (remaining_q != '0);
    assign pldWindow    = (state_q == PLD) | ((state_q == SIZE) & drain);
    assign pldLoad      = payload_valid & payload_ready;

    assign payload_ready = pldWindow & hasRemaining & stageFree;
    assign busy          = (state_q != IDLE);
    assign pkt_sent      = (state_q == DONE);
    assign clock_tx      = clock;
    assign tx            = tx_q;
    assign data_out      = data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tx_q        <= 1'b0;
            data_q      <= '0;
            size_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            data_q      <= data_d;
            size_q      <= size_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        data_d      = data_q;
        size_d      = size_q;
        remaining_d = remaining_q;

        unique case (state_q)
            IDLE: begin
                if (send_start) begin
                    size_d      = send_size;
                    remaining_d = SIZE_WIDTH'(send_size);
                    data_d      = send_target;
                    tx_d        = 1'b1;
                    state_d     = HDR;
                end
            end

            HDR: begin
                if (drain) begin
                    data_d  = size_q;
                    tx_d    = 1'b1;
                    state_d = SIZE;
                end
            end

            SIZE: begin
                if (drain) begin
                    if (!hasRemaining) begin
                        tx_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = PLD;
                        if (pldLoad) begin
                            data_d      = payload_data;
                            tx_d        = 1'b1;
                            remaining_d = remaining_q - SIZE_WIDTH'(1);
                        end else begin
                            tx_d = 1'b0;
                        end
                    end
                end
            end

            PLD: begin
                // A missing payload while draining leaves a bubble rather than resending.
                if (pldLoad) begin
                    data_d      = payload_data;
                    tx_d        = 1'b1;
                    remaining_d = remaining_q - SIZE_WIDTH'(1);
                end else if (!hasRemaining && (drain || !tx_q)) begin
                    tx_d    = 1'b0;
                    state_d = DONE;
                end else if (drain) begin
                    tx_d = 1'b0;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hermes_ni_sender.sv
// Scoreboard bench for hermes_ni_sender: expected flits are queued when a
// packet is requested and compared whenever a credited transfer occurs.
module tb_hermes_ni_sender;

    logic        clock;
    logic        reset;
    logic        send_start;
    logic [15:0] send_target;
    logic [15:0] send_size;
    logic        busy;
    logic        payload_valid;
    logic [15:0] payload_data;
    logic        payload_ready;
    logic        clock_tx;
    logic        tx;
    logic [15:0] data_out;
    logic        credit_i;
    logic        pkt_sent;

    logic [15:0] expQ[$];
    logic [15:0] pldQ[$];
    int          gapQ[$];
    bit          consumed;
    int          checkCount;
    int          errorCount;
    int          readyHighCount;
    int          bubbleCount;
    int          pktSentCount;

    hermes_ni_sender #(
        .FLIT_WIDTH(16),
        .SIZE_WIDTH(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .send_start   (send_start),
        .send_target  (send_target),
        .send_size    (send_size),
        .busy         (busy),
        .payload_valid(payload_valid),
        .payload_data (payload_data),
        .payload_ready(payload_ready),
        .clock_tx     (clock_tx),
        .tx           (tx),
        .data_out     (data_out),
        .credit_i     (credit_i),
        .pkt_sent     (pkt_sent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Transfers are judged at the falling edge, half a cycle before they take effect.
    always @(negedge clock) begin
        if (reset) begin
            if (tx && credit_i) begin
                if (expQ.size() == 0)
                    checkOutput("unexpected flit", {31'b0, tx}, 32'h0);
                else
                    checkOutput("flit", {16'h0, data_out}, {16'h0, expQ.pop_front()});
            end
            consumed = payload_valid && payload_ready;
            if (payload_ready) readyHighCount++;
            if (busy && !tx && !pkt_sent) bubbleCount++;
            if (pkt_sent) pktSentCount++;
        end else begin
            consumed = 1'b0;
        end
    end

    // Advance one cycle and present the next payload flit, honouring any gap request.
    task automatic nextCycle();
        @(posedge clock);
        #1;
        if (consumed && pldQ.size() > 0) begin
            void'(pldQ.pop_front());
            void'(gapQ.pop_front());
        end
        consumed = 1'b0;
        if (pldQ.size() > 0) begin
            if (gapQ[0] > 0) begin
                gapQ[0] = gapQ[0] - 1;
                payload_valid = 1'b0;
            end else begin
                payload_valid = 1'b1;
                payload_data  = pldQ[0];
            end
        end else begin
            payload_valid = 1'b0;
            payload_data  = 16'h0;
        end
    endtask

    task automatic resetCounters();
        readyHighCount = 0;
        bubbleCount    = 0;
        pktSentCount   = 0;
    endtask

    // Queue the expected flit sequence and payloads, then pulse send_start for one cycle.
    task automatic applyStimulus(input logic [15:0] target, input int size, input int gapBeforeSecond);
        expQ.push_back(target);
        expQ.push_back(16'(size));
        for (int i = 0; i < size; i++) begin
            logic [15:0] p;
            p = 16'h00A1 + 16'(i);
            expQ.push_back(p);
            pldQ.push_back(p);
            gapQ.push_back((i == 1) ? gapBeforeSecond : 0);
        end
        send_start  = 1'b1;
        send_target = target;
        send_size   = 16'(size);
        nextCycle();
        send_start  = 1'b0;
    endtask

    task automatic waitPacketDone(input string tag, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (pkt_sent) begin
                found = 1'b1;
                break;
            end
            nextCycle();
        end
        checkOutput({tag, " pkt_sent seen"}, {31'b0, found}, 32'h1);
        nextCycle();
        checkOutput({tag, " busy after done"}, {31'b0, busy}, 32'h0);
        checkOutput({tag, " flits left"}, expQ.size(), 32'h0);
        checkOutput({tag, " payload left"}, pldQ.size(), 32'h0);
    endtask

    initial begin
        bit found;
        checkCount    = 0;
        errorCount    = 0;
        consumed      = 1'b0;
        reset         = 1'b0;
        send_start    = 1'b0;
        send_target   = 16'h0;
        send_size     = 16'h0;
        payload_valid = 1'b0;
        payload_data  = 16'h0;
        credit_i      = 1'b1;
        resetCounters();

        #2;
        checkOutput("reset tx", {31'b0, tx}, 32'h0);
        checkOutput("reset data_out", {16'h0, data_out}, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        checkOutput("reset payload_ready", {31'b0, payload_ready}, 32'h0);
        checkOutput("reset pkt_sent", {31'b0, pkt_sent}, 32'h0);
        checkOutput("clock_tx follows clock", {31'b0, clock_tx}, {31'b0, clock});
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();

        $display("[TB] basic packet");
        resetCounters();
        applyStimulus(16'h0011, 3, 0);
        waitPacketDone("basic", 50);
        checkOutput("basic bubbles", bubbleCount, 32'h0);
        checkOutput("basic pkt_sent pulses", pktSentCount, 32'h1);

        $display("[TB] backpressure on header");
        resetCounters();
        applyStimulus(16'h0011, 3, 0);
        credit_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("stall tx", {31'b0, tx}, 32'h1);
            checkOutput("stall data_out", {16'h0, data_out}, 32'h0011);
            checkOutput("stall payload_ready", {31'b0, payload_ready}, 32'h0);
            nextCycle();
        end
        credit_i = 1'b1;
        waitPacketDone("stall", 50);
        checkOutput("stall pkt_sent pulses", pktSentCount, 32'h1);

        $display("[TB] payload bubbles");
        resetCounters();
        applyStimulus(16'h0011, 2, 2);
        waitPacketDone("bubble", 50);
        checkOutput("bubble idle cycles", bubbleCount, 32'h2);
        checkOutput("bubble pkt_sent pulses", pktSentCount, 32'h1);

        $display("[TB] zero size");
        resetCounters();
        applyStimulus(16'h0102, 0, 0);
        waitPacketDone("zero", 50);
        checkOutput("zero payload_ready cycles", readyHighCount, 32'h0);
        checkOutput("zero pkt_sent pulses", pktSentCount, 32'h1);

        $display("[TB] start while busy");
        resetCounters();
        applyStimulus(16'h0011, 3, 0);
        nextCycle();
        send_start  = 1'b1;
        send_target = 16'h0777;
        send_size   = 16'h0001;
        nextCycle();
        nextCycle();
        send_start  = 1'b0;
        waitPacketDone("busy start", 50);
        for (int i = 0; i < 4; i++) nextCycle();
        checkOutput("busy start stays idle", {31'b0, busy}, 32'h0);
        checkOutput("busy start pkt_sent pulses", pktSentCount, 32'h1);

        $display("[TB] reset mid-packet");
        resetCounters();
        applyStimulus(16'h0011, 5, 0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (tx && data_out == 16'h00A2) begin
                found = 1'b1;
                break;
            end
            nextCycle();
        end
        checkOutput("reach payload 2", {31'b0, found}, 32'h1);
        #1 reset = 1'b0;
        #1;
        checkOutput("abort tx", {31'b0, tx}, 32'h0);
        checkOutput("abort busy", {31'b0, busy}, 32'h0);
        checkOutput("abort pkt_sent", {31'b0, pkt_sent}, 32'h0);
        expQ.delete();
        pldQ.delete();
        gapQ.delete();
        consumed = 1'b0;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();
        resetCounters();
        applyStimulus(16'h0011, 1, 0);
        waitPacketDone("after reset", 50);
        checkOutput("after reset pkt_sent pulses", pktSentCount, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
